// File: rtl/seq_det_ctrl_if.sv
// Configuration handshake, serial data stream and status bundle for seq_det_ctrl.
interface seq_det_ctrl_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cfg_err;
  logic               start;
  logic               stop;
  logic               in;
  logic               in_valid;
  logic               out;
  logic [CNT_W-1:0]   match_cnt;
  logic               sat;
  logic               busy;

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, start, stop, in, in_valid,
    output cfg_ready, cfg_err, out, match_cnt, sat, busy
  );

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, start, stop, in, in_valid,
    input  cfg_ready, cfg_err, out, match_cnt, sat, busy
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// Run-time programmable serial pattern detector: IDLE/ARMED/RUN sequencing,
// Mealy match output and saturating match counter.
module seq_det_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  seq_det_ctrl_if.slave  bus
);

  localparam int FILL_W = $clog2(MAX_LEN + 1);
  localparam int CMP_W  = ((LEN_W > FILL_W) ? LEN_W : FILL_W) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               busy_q, rdy_q, sat_q;

  logic [MAX_LEN-1:0] win, bit_ok;
  logic               fill_ok, cfg_ok, match;
  logic               unused_hist_top;

  // Window is the newest MAX_LEN bits including the bit on the wire now;
  // the oldest history bit therefore never takes part in a compare.
  assign win             = {hist_q[MAX_LEN-2:0], bus.in};
  assign unused_hist_top = hist_q[MAX_LEN-1];

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_cmp
    assign bit_ok[i] = (CMP_W'(i) >= CMP_W'(len_q)) | (win[i] == pat_q[i]);
  end

  assign fill_ok = (CMP_W'(fill_q) + CMP_W'(1)) >= CMP_W'(len_q);
  assign match   = (state_q == S_RUN) & bus.in_valid & fill_ok & (&bit_ok);
  assign cfg_ok  = (CMP_W'(bus.cfg_len) >= CMP_W'(2)) &&
                   (CMP_W'(bus.cfg_len) <= CMP_W'(MAX_LEN));

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE, S_ARMED: begin
        // A configuration offer takes priority over start.
        if (bus.cfg_valid) begin
          if (cfg_ok) begin
            pat_d   = bus.cfg_pattern;
            len_d   = bus.cfg_len;
            ovl_d   = bus.cfg_overlap;
            hist_d  = '0;
            fill_d  = '0;
            state_d = S_ARMED;
          end else begin
            err_d = 1'b1;
          end
        end else if ((state_q == S_ARMED) && bus.start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          hist_d  = '0;
          fill_d  = '0;
        end
      end
      S_RUN: begin
        if (bus.in_valid) begin
          hist_d = win;
          if (CMP_W'(fill_q) < CMP_W'(MAX_LEN)) fill_d = fill_q + FILL_W'(1);
          if (match) begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            if (!ovl_q) fill_d = '0;
          end
        end
        if (bus.stop) state_d = S_ARMED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b1;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      busy_q  <= (state_d == S_RUN);
      rdy_q   <= (state_d != S_RUN);
      sat_q   <= &cnt_d;
    end
  end

  assign bus.out       = match;
  assign bus.cfg_ready = rdy_q;
  assign bus.cfg_err   = err_q;
  assign bus.busy      = busy_q;
  assign bus.match_cnt = cnt_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Bench for seq_det_ctrl: two instances (8-bit and 2-bit counters) share one
// stimulus stream and are compared each cycle against a bit-queue model.
module tb_seq_det_ctrl;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               cfg_valid, cfg_overlap, start, stop, din, in_valid;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;

  seq_det_ctrl_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) if8 ();
  seq_det_ctrl_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) if2 ();

  assign if8.cfg_valid   = cfg_valid;
  assign if8.cfg_pattern = cfg_pattern;
  assign if8.cfg_len     = cfg_len;
  assign if8.cfg_overlap = cfg_overlap;
  assign if8.start       = start;
  assign if8.stop        = stop;
  assign if8.in          = din;
  assign if8.in_valid    = in_valid;
  assign if2.cfg_valid   = cfg_valid;
  assign if2.cfg_pattern = cfg_pattern;
  assign if2.cfg_len     = cfg_len;
  assign if2.cfg_overlap = cfg_overlap;
  assign if2.start       = start;
  assign if2.stop        = stop;
  assign if2.in          = din;
  assign if2.in_valid    = in_valid;

  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .bus(if8.slave));
  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(if2.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: mode 0 = unconfigured, 1 = configured, 2 = detecting.
  int m_mode, m_pat, m_len, m_cnt;
  bit m_ovl, m_err;
  bit seen[$];  // bits received since last clear, oldest first

  function automatic bit m_hit(input bit b);
    int n;
    bit r;
    if (m_mode != 2) return 1'b0;
    n = seen.size();
    if (n + 1 < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      r = (k == 0) ? b : seen[n - k];
      if (r != ((m_pat >> k) & 1)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic m_update();
    bit hit;
    if (rst) begin
      m_mode = 0; m_pat = 0; m_len = 0; m_ovl = 0; m_cnt = 0; m_err = 0;
      seen.delete();
      return;
    end
    m_err = 0;
    if (m_mode != 2 && cfg_valid) begin
      if (cfg_len >= 2 && cfg_len <= MAX_LEN) begin
        m_pat = int'(cfg_pattern); m_len = int'(cfg_len); m_ovl = cfg_overlap;
        m_mode = 1;
        seen.delete();
      end else begin
        m_err = 1;
      end
    end else if (m_mode == 1 && start) begin
      m_mode = 2; m_cnt = 0;
      seen.delete();
    end else if (m_mode == 2) begin
      if (in_valid) begin
        hit = m_hit(din);
        seen.push_back(din);
        if (seen.size() > MAX_LEN) void'(seen.pop_front());
        if (hit) begin
          if (m_cnt < 1000) m_cnt++;
          if (!m_ovl) seen.delete();
        end
      end
      if (stop) m_mode = 1;
    end
  endtask

  task automatic step(input string tag);
    bit eo;
    int c8, c2;
    @(negedge clk);
    eo = in_valid && m_hit(din);
    c8 = (m_cnt > 255) ? 255 : m_cnt;
    c2 = (m_cnt > 3) ? 3 : m_cnt;
    chk({tag, ".out8"},  32'(if8.out),       32'(eo));
    chk({tag, ".out2"},  32'(if2.out),       32'(eo));
    chk({tag, ".busy"},  32'(if8.busy),      32'(m_mode == 2));
    chk({tag, ".rdy"},   32'(if8.cfg_ready), 32'(m_mode != 2));
    chk({tag, ".err"},   32'(if8.cfg_err),   32'(m_err));
    chk({tag, ".cnt8"},  32'(if8.match_cnt), 32'(c8));
    chk({tag, ".sat8"},  32'(if8.sat),       32'(c8 == 255));
    chk({tag, ".cnt2"},  32'(if2.match_cnt), 32'(c2));
    chk({tag, ".sat2"},  32'(if2.sat),       32'(c2 == 3));
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic quiet();
    rst = 0; cfg_valid = 0; start = 0; stop = 0; in_valid = 0; din = 0;
  endtask

  task automatic do_cfg(input logic [MAX_LEN-1:0] p, input int l, input bit o);
    cfg_pattern = p; cfg_len = LEN_W'(l); cfg_overlap = o; cfg_valid = 1;
    step("cfg");
    cfg_valid = 0;
  endtask

  task automatic do_start();
    start = 1; step("start"); start = 0;
  endtask

  task automatic send(input bit b);
    din = b; in_valid = 1; step("bit"); in_valid = 0; din = 0;
  endtask

  task automatic do_reset();
    quiet(); rst = 1; step("rst"); rst = 0;
  endtask

  initial begin
    quiet();
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0;
    rst = 1;
    @(posedge clk);
    m_update();
    #1;
    step("reset");
    rst = 0;
    step("idle");

    // Non-overlapping 101 on 1,0,1,0,1
    do_cfg(8'b101, 3, 0);
    do_start();
    send(1); send(0); send(1); send(0); send(1);
    chk("t1.cnt", 32'(if8.match_cnt), 32'd1);

    // Same stream, overlapping
    stop = 1; step("stop"); stop = 0;
    do_cfg(8'b101, 3, 1);
    do_start();
    send(1); send(0); send(1); send(0); send(1);
    chk("t2.cnt", 32'(if8.match_cnt), 32'd2);

    // Gap of invalid cycles inside a match
    stop = 1; step("stop"); stop = 0;
    do_start();
    send(1); send(0);
    din = 1; step("gap"); step("gap"); step("gap"); din = 0;
    send(1);
    chk("t3.cnt", 32'(if8.match_cnt), 32'd1);

    // Illegal lengths in IDLE, then cfg attempt during RUN
    do_reset();
    do_cfg(8'b1, 1, 0);
    chk("t4.err_len1", 32'(if8.cfg_err), 32'd1);
    step("t4");
    do_cfg(8'hFF, MAX_LEN + 1, 0);
    chk("t4.err_len9", 32'(if8.cfg_err), 32'd1);
    do_start();
    chk("t4.idle_start", 32'(if8.busy), 32'd0);
    do_cfg(8'b11, 2, 1);
    do_start();
    cfg_pattern = 8'b000; cfg_len = 4'd3; cfg_valid = 1;
    step("t4.runcfg");
    chk("t4.rdy", 32'(if8.cfg_ready), 32'd0);
    cfg_valid = 0;
    send(1); send(1);
    chk("t4.cnt", 32'(if8.match_cnt), 32'd1);

    // Saturation: six ones on pattern 11 overlapping
    stop = 1; step("stop"); stop = 0;
    do_start();
    for (int i = 0; i < 6; i++) send(1);
    chk("t5.cnt2", 32'(if2.match_cnt), 32'd3);
    chk("t5.sat2", 32'(if2.sat), 32'd1);
    chk("t5.cnt8", 32'(if8.match_cnt), 32'd5);

    // Reset on the completing bit, then stop on the completing bit
    stop = 1; step("stop"); stop = 0;
    do_cfg(8'b101, 3, 0);
    do_start();
    send(1); send(0);
    din = 1; in_valid = 1; rst = 1;
    step("t6.rst");
    quiet();
    chk("t6.busy", 32'(if8.busy), 32'd0);
    chk("t6.cnt", 32'(if8.match_cnt), 32'd0);
    chk("t6.rdy", 32'(if8.cfg_ready), 32'd1);
    do_start();
    chk("t6.nostart", 32'(if8.busy), 32'd0);
    do_cfg(8'b101, 3, 0);
    do_start();
    send(1); send(0);
    din = 1; in_valid = 1; stop = 1;
    step("t6.stop");
    quiet();
    chk("t6.stopcnt", 32'(if8.match_cnt), 32'd1);
    chk("t6.armed", 32'(if8.busy), 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      cfg_valid   = ($urandom_range(0, 19) == 0);
      cfg_len     = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 15))
                                                : LEN_W'($urandom_range(2, 4));
      cfg_pattern = MAX_LEN'($urandom);
      cfg_overlap = $urandom_range(0, 1);
      start       = ($urandom_range(0, 11) == 0);
      stop        = ($urandom_range(0, 59) == 0);
      in_valid    = ($urandom_range(0, 4) != 0);
      din         = $urandom_range(0, 1);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
